polymul_seq_mac: RTL and testbench



---
 rtl/polymul_pkg.sv | 19 +
 rtl/polymul_mac_lane.sv | 29 ++
 rtl/polymul_seq_mac.sv | 97 +++++++++
 tb/tb_polymul_seq_mac.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/polymul_pkg.sv
// Shared types and arithmetic helper for the sequential polynomial multiplier.
// mod_mac works at a fixed wide width; callers truncate to their coefficient width.
package polymul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N_DEFAULT = 4;
  localparam int KW = $clog2(N_DEFAULT);
  localparam int MACW = 32;

  // Low bits of an unsigned-by-signed product are identical under two's complement,
  // so a plain wide multiply followed by truncation gives the mod 2^QW result.
  function automatic logic [MACW-1:0] mod_mac(input logic [MACW-1:0] acc,
                                              input logic [MACW-1:0] a,
                                              input logic signed [MACW-1:0] s);
    return acc + a * s;
  endfunction

endpackage

// File: rtl/polymul_mac_lane.sv
// One result coefficient: QW-bit accumulator that adds sext(s)*a per enabled cycle.
module polymul_mac_lane
  import polymul_pkg::*;
#(
  parameter int QW = 4,
  parameter int SW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 mac_en,
  input  logic [QW-1:0]        a,
  input  logic signed [SW-1:0] s,
  output logic [QW-1:0]        acc
);

  logic [QW-1:0] acc_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_reg <= '0;
    end else if (mac_en) begin
      acc_reg <= QW'(mod_mac(MACW'(acc_reg), MACW'(a), MACW'(s)));
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/polymul_seq_mac.sv
// Sequential schoolbook multiplier w = a*s mod (x^N +/- 1): one secret coefficient
// per cycle, applied to all N lanes while a_reg rotates by one position (times x).
module polymul_seq_mac
  import polymul_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int QW         = 4,
  parameter int SW         = 2,
  parameter int NEGACYCLIC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            accumulate,
  input  logic [N*QW-1:0] a_flat,
  input  logic [N*SW-1:0] s_flat,
  output logic            busy,
  output logic            done,
  output logic [N*QW-1:0] w_flat
);

  localparam int CW = $clog2(N);

  state_t              state_reg, state_next;
  logic [CW-1:0]       k_reg;
  logic [QW-1:0]       a_reg [N];
  logic [N*SW-1:0]     s_reg;
  logic signed [SW-1:0] s_lane [N];
  logic signed [SW-1:0] s_sel;
  logic                lane_clear, lane_mac;

  always_comb begin
    state_next = state_reg;
    lane_clear = 1'b0;
    lane_mac   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          lane_clear = ~accumulate;
        end
      end
      RUN: begin
        lane_mac = 1'b1;
        if (k_reg == CW'(N - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      s_reg     <= '0;
      for (int i = 0; i < N; i++) a_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        k_reg <= '0;
        s_reg <= s_flat;
        for (int i = 0; i < N; i++) a_reg[i] <= a_flat[i*QW +: QW];
      end else if (state_reg == RUN) begin
        k_reg <= k_reg + CW'(1);
        // Wrap of the top coefficient is where the reduction polynomial shows up.
        for (int i = 1; i < N; i++) a_reg[i] <= a_reg[i-1];
        a_reg[0] <= (NEGACYCLIC != 0) ? -a_reg[N-1] : a_reg[N-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign s_lane[gi] = s_reg[gi*SW +: SW];

      polymul_mac_lane #(
        .QW(QW),
        .SW(SW)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .clear  (lane_clear),
        .mac_en (lane_mac),
        .a      (a_reg[gi]),
        .s      (s_sel),
        .acc    (w_flat[gi*QW +: QW])
      );
    end
  endgenerate

  assign s_sel = s_lane[k_reg];
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_polymul_seq_mac.sv
// Scoreboard bench: two instances (negacyclic and cyclic) share stimulus; expected
// results come from a direct schoolbook model and are checked on each done pulse.
module tb_polymul_seq_mac;

  localparam int N  = 4;
  localparam int QW = 4;
  localparam int SW = 2;
  localparam int W  = N * QW;
  localparam int S  = N * SW;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         accumulate;
  logic [W-1:0] a_flat;
  logic [S-1:0] s_flat;
  logic         busy0, done0, busy1, done1;
  logic [W-1:0] w0, w1;

  int checks = 0;
  int errors = 0;
  int op_id  = 0;

  logic [W-1:0] q_neg[$];
  logic [W-1:0] q_cyc[$];
  logic [W-1:0] m_neg, m_cyc;

  always #5 clk = ~clk;

  polymul_seq_mac #(.N(N), .QW(QW), .SW(SW), .NEGACYCLIC(1)) dut_neg (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .a_flat(a_flat), .s_flat(s_flat), .busy(busy0), .done(done0), .w_flat(w0)
  );

  polymul_seq_mac #(.N(N), .QW(QW), .SW(SW), .NEGACYCLIC(0)) dut_cyc (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .a_flat(a_flat), .s_flat(s_flat), .busy(busy1), .done(done1), .w_flat(w1)
  );

  // Direct sum over all coefficient pairs; terms wrapping past x^N get negated if neg.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] af, input logic [S-1:0] sf,
                                           input bit neg);
    int acc[N];
    int idx, t;
    logic [QW-1:0] ac;
    logic signed [SW-1:0] sc;
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) acc[i] = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ac  = af[i*QW +: QW];
        sc  = sf[j*SW +: SW];
        t   = int'(ac) * int'(sc);
        idx = i + j;
        if (idx >= N) begin
          idx = idx - N;
          if (neg) t = -t;
        end
        acc[idx] = acc[idx] + t;
      end
    end
    r = '0;
    for (int k = 0; k < N; k++) r[k*QW +: QW] = QW'(acc[k]);
    return r;
  endfunction

  function automatic logic [W-1:0] wadd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[k*QW +: QW] = x[k*QW +: QW] + y[k*QW +: QW];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expectation per instance.
  always @(negedge clk) begin
    if (!reset && (done0 || done1)) begin
      checks++;
      if (!(done0 && done1) || q_neg.size() == 0 || q_cyc.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual=%0b%0b required=11 pending=%0d",
                 done0, done1, q_neg.size());
      end else begin
        logic [W-1:0] en, ec;
        en = q_neg.pop_front();
        ec = q_cyc.pop_front();
        op_id++;
        $display("op %0d w_neg=%h (exp %h) w_cyc=%h (exp %h)", op_id, w0, en, w1, ec);
        check("w_neg", 32'(w0), 32'(en));
        check("w_cyc", 32'(w1), 32'(ec));
      end
    end
  end

  task automatic push_model(input logic [W-1:0] af, input logic [S-1:0] sf, input bit acc,
                            input bit use_exp, input logic [W-1:0] exp_neg);
    m_neg = acc ? wadd(m_neg, ref_mul(af, sf, 1'b1)) : ref_mul(af, sf, 1'b1);
    m_cyc = acc ? wadd(m_cyc, ref_mul(af, sf, 1'b0)) : ref_mul(af, sf, 1'b0);
    q_neg.push_back(use_exp ? exp_neg : m_neg);
    q_cyc.push_back(m_cyc);
  endtask

  task automatic do_op(input logic [W-1:0] af, input logic [S-1:0] sf, input bit acc,
                       input bit mid_start, input bit use_exp, input logic [W-1:0] exp_neg);
    int cyc, busy_cnt;
    bit seen;
    push_model(af, sf, acc, use_exp, exp_neg);
    @(negedge clk);
    a_flat = af; s_flat = sf; accumulate = acc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_flat = W'($urandom); s_flat = S'($urandom); accumulate = 1'($urandom);
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    while (cyc <= 3 * N + 5) begin
      if (busy0) busy_cnt++;
      if (done0) begin
        seen = 1'b1;
        break;
      end
      start = (mid_start && cyc == 2);
      if (start) begin
        a_flat = W'($urandom); s_flat = S'($urandom); accumulate = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(N + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(N + 1));
    @(negedge clk);
    check("busy_after_done", 32'(busy0), 32'd0);
    check("w_hold", 32'(w0), 32'(use_exp ? exp_neg : m_neg));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; accumulate = 1'b0; a_flat = '0; s_flat = '0;
    m_neg = '0; m_cyc = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_done", 32'(done0), 32'd0);
    check("reset_w", 32'(w0), 32'd0);
    reset = 1'b0;

    do_op(16'h0865, 8'h01, 1'b0, 1'b0, 1'b1, 16'h0865);  // identity
    do_op(16'h4321, 8'h04, 1'b0, 1'b0, 1'b1, 16'h321C);  // times x
    do_op(16'h0865, 8'hC0, 1'b0, 1'b0, 1'b1, 16'hB086);  // times -x^3
    do_op(16'hFFFF, 8'h55, 1'b0, 1'b0, 1'b1, 16'hCE02);  // wrap-around
    do_op(16'h4321, 8'h01, 1'b0, 1'b0, 1'b1, 16'h4321);
    do_op(16'h4321, 8'h01, 1'b1, 1'b0, 1'b1, 16'h8642);
    do_op(16'h4321, 8'h01, 1'b0, 1'b0, 1'b1, 16'h4321);
    do_op(16'h4321, 8'h04, 1'b0, 1'b1, 1'b1, 16'h321C);  // start during RUN ignored

    // Reset two cycles into RUN aborts without a done pulse.
    push_model(16'h4321, 8'h55, 1'b0, 1'b0, '0);
    @(negedge clk);
    a_flat = 16'h4321; s_flat = 8'h55; accumulate = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_w", 32'(w0), 32'd0);
    void'(q_neg.pop_back());
    void'(q_cyc.pop_back());
    m_neg = '0; m_cyc = '0;

    // Reset together with start stays idle.
    start = 1'b1; reset = 1'b1; a_flat = 16'h1111; s_flat = 8'h55;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("start_reset_busy", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);
    check("start_reset_idle", 32'(busy0), 32'd0);
    check("start_reset_w", 32'(w0), 32'd0);

    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), S'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0, '0);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q_neg.size() + q_cyc.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
